regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-issue GPR + HI/LO file.
- Adds:
  - configurable width, address width and number of read ports;
  - optional write-to-read bypass;
  - asynchronous active-low clear of all state;
  - per-register pending-write scoreboard (busy bits) for the issue stage;
  - a 64-bit combined HI/LO write with its own busy flag for the multi-cycle mul/div unit.
- Sits between decode/issue (reads, busy set) and write-back (writes, busy clear).

Parameters:
- DATA_W, 32, width of each GPR and of HI/LO.
- ADDR_W, 5, GPR address width; register count = 2**ADDR_W.
- NUM_RD, 2, number of independent GPR read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  1 = register read on port i has a pending write.
- we  in  1  GPR write enable.
- waddr  in  ADDR_W  GPR write address.
- wdata  in  DATA_W  GPR write data.
- set_busy  in  1  mark set_addr pending (issued instruction will write it).
- set_addr  in  ADDR_W  register to mark pending.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- hi_we  in  1  HI write enable.
- lo_we  in  1  LO write enable.
- hilo_we  in  1  combined write: HI <= hilo_i[2*DATA_W-1:DATA_W], LO <= hilo_i[DATA_W-1:0].
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- hilo_i  in  2*DATA_W  combined HI/LO data.
- hilo_set_busy  in  1  mark HI/LO pending (mul/div issued).
- hi_o  out  DATA_W  HI read value.
- lo_o  out  DATA_W  LO read value.
- hilo_busy  out  1  HI/LO pending flag.

Behaviour:
- Reset (rst=0, async):
  - All GPRs, HI, LO, busy bits and hilo_busy go to 0 immediately.
  - Outputs read 0 / not busy while rst=0.
  - Any write or set_busy in flight is lost.
- Register 0:
  - Always reads 0 and rbusy=0.
  - Writes and set_busy to address 0 are ignored.
- GPR write: takes effect at the clock edge when we=1 and waddr!=0.
- Reads are combinational.
  - BYPASS=1: if we=1 and waddr==raddr_i!=0, rdata_i = wdata in the same cycle.
  - Otherwise rdata_i = stored value.
- Busy bits, per register, evaluated at each edge with this priority:
  - flush: all bits -> 0.
  - else set_busy on the register: bit -> 1.
  - else we write to the register: bit -> 0.
  - Consequence: a same-cycle set_busy and write to the same register leaves the bit 1, because the new producer wins.
- rbusy_i:
  - BYPASS=1: busy[raddr_i] & ~(we & waddr==raddr_i).
  - BYPASS=0: busy[raddr_i].
- HI/LO data write priority at the edge:
  - hilo_we overrides hi_we/lo_we for both halves.
  - Otherwise hi_we / lo_we update their own half independently.
- hi_o / lo_o:
  - BYPASS=1: forward the value being written this cycle, with the same priority as above.
  - BYPASS=0: registered values.
- hilo_busy, evaluated at each edge with this priority:
  - flush -> 0.
  - else hilo_set_busy -> 1.
  - else any of hilo_we/hi_we/lo_we -> 0.
- hilo_busy output masking when BYPASS=1: output hilo_busy & ~(hilo_we|hi_we|lo_we).
- Read latency: 0 cycles. Write-to-read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Duplicate read addresses on several ports are legal and return identical data.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - ZERO_REG address constant;
  - a function extracting field i from a packed port vector.
- One sub-module, hilo_unit:
  - holds HI, LO and hilo_busy;
  - implements the write priority and bypass;
  - parametrised by DATA_W and BYPASS.

Test Plan:
- rst=0 mid-run after writing 0xDEADBEEF to r5 -> rdata for r5 = 0 and all rbusy=0 immediately, before any clock edge.
- BYPASS=1: we=1, waddr=7, wdata=0x12345678, raddr0=7 in the same cycle -> rdata0=0x12345678 that cycle. BYPASS=0 -> old value that cycle, 0x12345678 the next.
- Write r0=0xFFFFFFFF and set_busy r0 -> rdata reads 0 and rbusy=0 on all ports.
- set_busy r3 at cycle 1 -> rbusy=1 at cycle 2. At cycle 4, set_busy r3 and we r3=0xA5 together -> busy stays 1 and data=0xA5. Flush at cycle 5 -> busy=0 at cycle 6.
- hilo_set_busy, then hilo_we=1 with hilo_i=0x00000001_00000002 and hi_we=1 with hi_i=0xFFFF same cycle -> hi_o=1, lo_o=2, hilo_busy=0 after the edge.
- NUM_RD=4: four ports read r1, r2, r1, r31 holding 0x11, 0x22, 0x11, 0x1F -> each port returns its own value, and rbusy reflects each address independently.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and packed-port field extraction for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REGF_DATA_W = 32;
  localparam int unsigned REGF_ADDR_W = 5;
  localparam int unsigned ZERO_REG    = 0;
  localparam int unsigned VEC_MAX_W   = 256;
  localparam int unsigned FIELD_MAX_W = 64;

  // Returns field idx (w bits wide) of a packed vector; callers cast the result to their width.
  function automatic logic [FIELD_MAX_W-1:0] get_field(input logic [VEC_MAX_W-1:0] vec,
                                                       input int unsigned idx,
                                                       input int unsigned w);
    logic [VEC_MAX_W-1:0] mask_v;
    logic [VEC_MAX_W-1:0] shifted_v;
    mask_v    = (VEC_MAX_W'(1'b1) << w) - VEC_MAX_W'(1'b1);
    shifted_v = (vec >> (idx * w)) & mask_v;
    return shifted_v[FIELD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO pair for the mul/div unit: write priority, optional forwarding and pending flag.
module hilo_unit
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGF_DATA_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic                hilo_we,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic                hilo_set_busy,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                hilo_busy
);

  logic [DATA_W-1:0] hi_r, lo_r, hi_nxt_s, lo_nxt_s;
  logic              busy_r, busy_nxt_s, any_we_s;

  assign any_we_s = hilo_we | hi_we | lo_we;

  // Next-state: combined write beats per-half writes; flush beats set beats clear.
  always_comb begin
    hi_nxt_s   = hi_r;
    lo_nxt_s   = lo_r;
    busy_nxt_s = busy_r;
    if (hilo_we) begin
      hi_nxt_s = hilo_i[2*DATA_W-1:DATA_W];
      lo_nxt_s = hilo_i[DATA_W-1:0];
    end else begin
      hi_nxt_s = hi_we ? hi_i : hi_r;
      lo_nxt_s = lo_we ? lo_i : lo_r;
    end
    if (flush)              busy_nxt_s = 1'b0;
    else if (hilo_set_busy) busy_nxt_s = 1'b1;
    else if (any_we_s)      busy_nxt_s = 1'b0;
    else                    busy_nxt_s = busy_r;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
    end else begin
      hi_r   <= hi_nxt_s;
      lo_r   <= lo_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Forwarding is held off during reset so outputs read zero while rst is low.
  always_comb begin
    if ((BYPASS != 32'd0) && rst) begin
      hi_o      = hi_nxt_s;
      lo_o      = lo_nxt_s;
      hilo_busy = busy_r & ~any_we_s;
    end else begin
      hi_o      = hi_r;
      lo_o      = lo_r;
      hilo_busy = busy_r;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port GPR file with pending-write scoreboard and HI/LO unit.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGF_DATA_W,
  parameter int unsigned ADDR_W = REGF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     flush,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic                     hilo_we,
  input  logic [DATA_W-1:0]        hi_i,
  input  logic [DATA_W-1:0]        lo_i,
  input  logic [2*DATA_W-1:0]      hilo_i,
  input  logic                     hilo_set_busy,
  output logic [DATA_W-1:0]        hi_o,
  output logic [DATA_W-1:0]        lo_o,
  output logic                     hilo_busy
);

  localparam int unsigned         NREG      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] gpr_r [NREG];
  logic [NREG-1:0]   busy_r, busy_nxt_s;
  logic              wr_ok_s, set_ok_s, fwd_ok_s;

  assign wr_ok_s  = we && (waddr != ZERO_ADDR);
  assign set_ok_s = set_busy && (set_addr != ZERO_ADDR);
  assign fwd_ok_s = (BYPASS != 32'd0) && rst && wr_ok_s;

  // GPR storage; register 0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) gpr_r[r] <= '0;
    end else if (wr_ok_s) begin
      gpr_r[waddr] <= wdata;
    end
  end

  // Scoreboard next-state: a new producer (set) wins over a retiring one (write).
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (set_ok_s && (set_addr == ADDR_W'(r)))  busy_nxt_s[r] = 1'b1;
        else if (wr_ok_s && (waddr == ADDR_W'(r))) busy_nxt_s[r] = 1'b0;
        else                                       busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_r <= '0;
    else      busy_r <= busy_nxt_s;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = ADDR_W'(get_field(VEC_MAX_W'(raddr), gi, ADDR_W));

    // Combinational read with optional same-cycle forwarding of the write port.
    always_comb begin
      if (!rst || (addr_s == ZERO_ADDR)) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if (fwd_ok_s && (waddr == addr_s)) begin
        data_s = wdata;
        busy_s = 1'b0;
      end else begin
        data_s = gpr_r[addr_s];
        busy_s = busy_r[addr_s];
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = data_s;
    assign rbusy[gi]                  = busy_s;
  end

  hilo_unit #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_hilo (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .hi_we         (hi_we),
    .lo_we         (lo_we),
    .hilo_we       (hilo_we),
    .hi_i          (hi_i),
    .lo_i          (lo_i),
    .hilo_i        (hilo_i),
    .hilo_set_busy (hilo_set_busy),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .hilo_busy     (hilo_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a 4-port forwarding instance and a 1-port registered-read instance share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] raddr;
  logic [127:0] rdata;
  logic [3:0]  rbusy;
  logic        we, set_busy, flush, hi_we, lo_we, hilo_we, hilo_set_busy;
  logic [4:0]  waddr, set_addr;
  logic [31:0] wdata, hi_i, lo_i, hi_o, lo_o;
  logic [63:0] hilo_i;
  logic        hilo_busy;
  logic [31:0] rdata_nb, hi_nb, lo_nb;
  logic [0:0]  rbusy_nb;
  logic        hbusy_nb;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [31:0] gpr_m [32];
  bit          busy_m [32];
  logic [31:0] hi_m, lo_m;
  bit          hbusy_m;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .set_busy(set_busy), .set_addr(set_addr),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .hilo_we(hilo_we), .hi_i(hi_i),
    .lo_i(lo_i), .hilo_i(hilo_i), .hilo_set_busy(hilo_set_busy), .hi_o(hi_o),
    .lo_o(lo_o), .hilo_busy(hilo_busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .raddr(raddr[4:0]), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .set_busy(set_busy), .set_addr(set_addr),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .hilo_we(hilo_we), .hi_i(hi_i),
    .lo_i(lo_i), .hilo_i(hilo_i), .hilo_set_busy(hilo_set_busy), .hi_o(hi_nb),
    .lo_o(lo_nb), .hilo_busy(hbusy_nb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 32'd0;
    if (byp && we && waddr == a) return wdata;
    return gpr_m[a];
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 1'b0;
    if (byp && we && waddr == a) return 1'b0;
    return busy_m[a];
  endfunction

  // HI/LO as they will be after this edge (what a forwarding reader should see now).
  function automatic logic [31:0] next_hi();
    if (hilo_we) return hilo_i[63:32];
    if (hi_we) return hi_i;
    return hi_m;
  endfunction

  function automatic logic [31:0] next_lo();
    if (hilo_we) return hilo_i[31:0];
    if (lo_we) return lo_i;
    return lo_m;
  endfunction

  task automatic check_all(input string tag);
    logic [4:0] a;
    for (int p = 0; p < 4; p++) begin
      a = raddr[p*5 +: 5];
      chk($sformatf("%s_rdata%0d", tag, p), {32'd0, rdata[p*32 +: 32]}, {32'd0, exp_rd(a, 1'b1)});
      chk($sformatf("%s_rbusy%0d", tag, p), {63'd0, rbusy[p]}, {63'd0, exp_rbusy(a, 1'b1)});
    end
    chk({tag, "_nb_rdata"}, {32'd0, rdata_nb}, {32'd0, exp_rd(raddr[4:0], 1'b0)});
    chk({tag, "_nb_rbusy"}, {63'd0, rbusy_nb}, {63'd0, exp_rbusy(raddr[4:0], 1'b0)});
    chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, rst ? next_hi() : 32'd0});
    chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, rst ? next_lo() : 32'd0});
    chk({tag, "_hbusy"}, {63'd0, hilo_busy},
        {63'd0, rst && hbusy_m && !(hilo_we || hi_we || lo_we)});
    chk({tag, "_nb_hi"}, {32'd0, hi_nb}, {32'd0, hi_m});
    chk({tag, "_nb_lo"}, {32'd0, lo_nb}, {32'd0, lo_m});
    chk({tag, "_nb_hbusy"}, {63'd0, hbusy_nb}, {63'd0, hbusy_m});
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin gpr_m[r] = 32'd0; busy_m[r] = 1'b0; end
    hi_m = 32'd0; lo_m = 32'd0; hbusy_m = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst) return;
    if (we && waddr != 5'd0) gpr_m[waddr] = wdata;
    if (flush) begin
      for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    end else begin
      if (we && waddr != 5'd0) busy_m[waddr] = 1'b0;
      if (set_busy && set_addr != 5'd0) busy_m[set_addr] = 1'b1;
    end
    hi_m = next_hi();
    lo_m = next_lo();
    if (flush) hbusy_m = 1'b0;
    else if (hilo_set_busy) hbusy_m = 1'b1;
    else if (hilo_we || hi_we || lo_we) hbusy_m = 1'b0;
  endtask

  // Check with current inputs, then let one edge happen and update the model.
  task automatic tick(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; set_busy = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    hilo_we = 1'b0; hilo_set_busy = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    raddr = {a3, a2, a1, a0};
  endtask

  initial begin
    rst = 1'b0; idle(); model_reset();
    waddr = 5'd0; wdata = 32'd0; set_addr = 5'd0; hi_i = 32'd0; lo_i = 32'd0; hilo_i = 64'd0;
    set_rd(5'd1, 5'd2, 5'd3, 5'd4);
    tick("reset");
    rst = 1'b1;

    // Write r5, mark it busy, then async reset mid-cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_rd(5'd5, 5'd5, 5'd0, 5'd6);
    tick("wr5");
    idle(); set_busy = 1'b1; set_addr = 5'd5;
    tick("busy5");
    idle();
    #1 chk("r5_before_rst", {32'd0, rdata[31:0]}, {32'd0, 32'hDEADBEEF});
    rst = 1'b0; model_reset();
    #1 chk("r5_async_rst", {32'd0, rdata[31:0]}, 64'd0);
    chk("rbusy_async_rst", {60'd0, rbusy}, 64'd0);
    tick("in_rst");
    rst = 1'b1;

    // Same-cycle forwarding vs registered read
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; set_rd(5'd7, 5'd7, 5'd7, 5'd7);
    #1 chk("byp_same_cycle", {32'd0, rdata[31:0]}, {32'd0, 32'h12345678});
    chk("nobyp_same_cycle", {32'd0, rdata_nb}, 64'd0);
    tick("wr7");
    idle();
    #1 chk("nobyp_next_cycle", {32'd0, rdata_nb}, {32'd0, 32'h12345678});

    // Register 0 ignores writes and busy marks
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_busy = 1'b1; set_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    tick("r0_wr");
    idle();
    #1 chk("r0_data", {32'd0, rdata[31:0]}, 64'd0);
    chk("r0_busy", {60'd0, rbusy}, 64'd0);

    // Scoreboard: set, set+write collide, flush
    set_rd(5'd3, 5'd0, 5'd0, 5'd0);
    set_busy = 1'b1; set_addr = 5'd3;
    tick("set3");
    idle();
    #1 chk("r3_busy", {63'd0, rbusy[0]}, 64'd1);
    tick("idle3");
    set_busy = 1'b1; set_addr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h000000A5;
    tick("set_wr3");
    idle();
    #1 chk("r3_busy_kept", {63'd0, rbusy[0]}, 64'd1);
    chk("r3_data", {32'd0, rdata[31:0]}, {32'd0, 32'h000000A5});
    flush = 1'b1;
    tick("flush");
    idle();
    #1 chk("r3_flushed", {63'd0, rbusy[0]}, 64'd0);

    // HI/LO: combined write beats per-half write and clears pending
    hilo_set_busy = 1'b1;
    tick("hset");
    idle();
    #1 chk("hbusy_set", {63'd0, hilo_busy}, 64'd1);
    hilo_we = 1'b1; hilo_i = 64'h00000001_00000002; hi_we = 1'b1; hi_i = 32'h0000FFFF;
    tick("hwr");
    idle();
    #1 chk("hi_after", {32'd0, hi_o}, 64'd1);
    chk("lo_after", {32'd0, lo_o}, 64'd2);
    chk("hbusy_after", {63'd0, hilo_busy}, 64'd0);

    // Four independent ports
    we = 1'b1; waddr = 5'd1; wdata = 32'h11; tick("w1");
    waddr = 5'd2; wdata = 32'h22; tick("w2");
    waddr = 5'd31; wdata = 32'h1F; tick("w31");
    idle(); set_busy = 1'b1; set_addr = 5'd2; tick("set2");
    idle(); set_rd(5'd1, 5'd2, 5'd1, 5'd31);
    #1 chk("p4_data", {rdata[127:96], rdata[95:64]}, {32'h1F, 32'h11});
    chk("p4_data_lo", {rdata[63:32], rdata[31:0]}, {32'h22, 32'h11});
    chk("p4_busy", {60'd0, rbusy}, {60'd0, 4'b0010});
    tick("p4");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      if (!rst) model_reset();
      we = $urandom_range(0, 1); waddr = 5'($urandom_range(0, 7)); wdata = $urandom;
      set_busy = ($urandom_range(0, 3) == 0); set_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      hi_we = ($urandom_range(0, 3) == 0); lo_we = ($urandom_range(0, 3) == 0);
      hilo_we = ($urandom_range(0, 5) == 0); hilo_set_busy = ($urandom_range(0, 4) == 0);
      hi_i = $urandom; lo_i = $urandom; hilo_i = {$urandom, $urandom};
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
